// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    HELD  = 2'd1,
    ABORT = 2'd2
  } fetch_state_t;

  // How the IF/ID register updates this cycle
  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_LOAD   = 2'd1,
    IFID_BUBBLE = 2'd2,
    IFID_FLUSH  = 2'd3
  } ifid_op_t;

  typedef enum logic [1:0] {
    SRC_MEM = 2'd0,
    SRC_BUF = 2'd1,
    SRC_NOP = 2'd2
  } ifid_src_t;

  typedef struct packed {
    ifid_op_t  ifid_op;
    ifid_src_t src;
    logic      pc_load;
    logic      ibuf_load;
    logic      abort_load;
  } fetch_ctrl_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/fetch_fsm.sv
// Fetch handshake FSM: decides when to request, buffer, abort and load IF/ID.
module fetch_fsm
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ack,
  input  logic         stall,
  input  logic         flush,
  input  logic         adel,
  output fetch_state_t state,
  output logic         req,
  output fetch_ctrl_t  ctrl
);

  fetch_state_t nxt;
  logic         issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= REQ;
    else        state <= nxt;
  end

  always_comb begin
    nxt   = state;
    ctrl  = '0;
    issue = 1'b0;
    unique case (state)
      REQ: begin
        issue = !adel;
        if (flush) begin
          ctrl.ifid_op = IFID_FLUSH;
          ctrl.pc_load = 1'b1;
          // An unacked request must still be completed by the memory
          if (issue && !ack) begin
            nxt             = ABORT;
            ctrl.abort_load = 1'b1;
          end
        end else if (adel) begin
          if (!stall) begin
            ctrl.ifid_op = IFID_LOAD;
            ctrl.src     = SRC_NOP;
            ctrl.pc_load = 1'b1;
          end
        end else if (ack) begin
          if (!stall) begin
            ctrl.ifid_op = IFID_LOAD;
            ctrl.src     = SRC_MEM;
            ctrl.pc_load = 1'b1;
          end else begin
            ctrl.ibuf_load = 1'b1;
            nxt            = HELD;
          end
        end else if (!stall) begin
          ctrl.ifid_op = IFID_BUBBLE;
        end
      end
      HELD: begin
        if (flush) begin
          ctrl.ifid_op = IFID_FLUSH;
          ctrl.pc_load = 1'b1;
          nxt          = REQ;
        end else if (!stall) begin
          ctrl.ifid_op = IFID_LOAD;
          ctrl.src     = SRC_BUF;
          ctrl.pc_load = 1'b1;
          nxt          = REQ;
        end
      end
      ABORT: begin
        issue = 1'b1;
        if (flush) begin
          ctrl.ifid_op = IFID_FLUSH;
          ctrl.pc_load = 1'b1;
        end
        // Stay until the old request drains so imem_addr never moves mid-request
        if (ack) nxt = REQ;
      end
      default: nxt = REQ;
    endcase
    req = issue & rst_n;
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC, imem req/ack fetch, IF/ID register.
// Optional misaligned-fetch detection via `FETCH_ALIGN_CHK_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic        stallD,
  input  logic        flushD,
  output logic [31:0] pcplus,
  output logic [31:0] pcF,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pcplusD,
  output logic        validD
`ifdef FETCH_ALIGN_CHK_EN
  , output logic      adelF
`endif
);

  logic [31:0]  pc, ibuf, abort_pc, fetch_addr;
  logic         adel;
  fetch_state_t state;
  fetch_ctrl_t  ctrl;

  assign pcF        = pc;
  assign pcplus     = pc + 32'd4;
  assign fetch_addr = (state == ABORT) ? abort_pc : pc;

`ifdef FETCH_ALIGN_CHK_EN
  assign adel      = (pc[1:0] != 2'b00);
  assign adelF     = adel;
  assign imem_addr = fetch_addr;
`else
  assign adel      = 1'b0;
  assign imem_addr = fetch_addr & 32'hFFFF_FFFC;
`endif

  fetch_fsm u_fsm (
    .clk   (clk),
    .rst_n (rst_n),
    .ack   (imem_ack),
    .stall (stallD),
    .flush (flushD),
    .adel  (adel),
    .state (state),
    .req   (imem_req),
    .ctrl  (ctrl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      ibuf     <= NOP_INSTR;
      abort_pc <= 32'h0;
      instrD   <= NOP_INSTR;
      pcplusD  <= 32'h0;
      validD   <= 1'b0;
    end else begin
      if (ctrl.pc_load)    pc       <= address;
      if (ctrl.ibuf_load)  ibuf     <= imem_rdata;
      if (ctrl.abort_load) abort_pc <= pc;
      unique case (ctrl.ifid_op)
        IFID_LOAD: begin
          unique case (ctrl.src)
            SRC_MEM: instrD <= imem_rdata;
            SRC_BUF: instrD <= ibuf;
            default: instrD <= NOP_INSTR;
          endcase
          pcplusD <= pcplus;
          validD  <= 1'b1;
        end
        IFID_BUBBLE: begin
          instrD <= NOP_INSTR;
          validD <= 1'b0;
        end
        IFID_FLUSH: begin
          instrD  <= NOP_INSTR;
          pcplusD <= 32'h0;
          validD  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
